// File: rtl/fifo_pkg.sv
// Shared types and default parameters for the FIFO read packer.
package fifo_pkg;
  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_e;

  localparam int DEF_WIDTH   = 8;
  localparam int DEF_BYTES   = 4;
  localparam int DEF_TIMEOUT = 16;
endpackage

// File: rtl/fifo_rd_packer_if.sv
// FIFO read side plus packed-word valid/ready side of the read packer.
interface fifo_rd_packer_if #(
  parameter int WIDTH = fifo_pkg::DEF_WIDTH,
  parameter int BYTES = fifo_pkg::DEF_BYTES
);
  logic                   empty;
  logic [WIDTH-1:0]       rdata;
  logic                   rd_error;
  logic                   rd_en;
  logic [WIDTH*BYTES-1:0] out_data;
  logic [BYTES-1:0]       out_keep;
  logic                   out_valid;
  logic                   out_ready;
  logic                   underflow;

  modport master (
    input  empty, rdata, rd_error, out_ready,
    output rd_en, out_data, out_keep, out_valid, underflow
  );

  modport slave (
    output empty, rdata, rd_error, out_ready,
    input  rd_en, out_data, out_keep, out_valid, underflow
  );
endinterface

// File: rtl/fifo_flush_timer.sv
// Idle counter that fires once TIMEOUT consecutive idle cycles have elapsed.
module fifo_flush_timer
  import fifo_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic rd_clk,
  input  logic reset,
  input  logic clr_i,
  input  logic run_i,
  output logic expire_o
);
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] t_q, t_d;

  assign expire_o = run_i && (int'(t_q) == TIMEOUT - 1);

  // Non-idle cycles without a clear leave the count where it is.
  always_comb begin
    t_d = t_q;
    if (clr_i || expire_o) t_d = '0;
    else if (run_i)        t_d = t_q + TW'(1);
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) t_q <= '0;
    else       t_q <= t_d;
  end
endmodule

// File: rtl/fifo_rd_packer.sv
// Packs BYTES consecutive FIFO bytes into one word behind a valid/ready handshake.
// Define FIFO_RD_PACKER_FLUSH_EN to emit partial words after TIMEOUT idle cycles.
module fifo_rd_packer
  import fifo_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int BYTES   = DEF_BYTES,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input logic              rd_clk,
  input logic              reset,
  fifo_rd_packer_if.master bus
);
  localparam int CW = $clog2(BYTES + 1);
  localparam int LW = $clog2(BYTES);

  if (BYTES < 2 || (BYTES & (BYTES - 1)) != 0 || TIMEOUT < 1) begin : g_bad_cfg
    $error("fifo_rd_packer: BYTES must be a power of two >= 2 and TIMEOUT >= 1");
  end

  state_e                       state_q, state_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic                         pend_q;
  logic [BYTES-1:0][WIDTH-1:0]  data_q, data_d;
  logic [BYTES-1:0]             keep_q, keep_d;
  logic                         uf_q, uf_d;
  logic                         rd_en, capture, flush;

  // Gating by reset keeps a read from escaping while the block is held in reset.
  assign rd_en   = !reset && (state_q == FILL) && !bus.empty &&
                   (int'(cnt_q) + int'(pend_q) < BYTES);
  assign capture = (state_q == FILL) && pend_q && !bus.rd_error;

`ifdef FIFO_RD_PACKER_FLUSH_EN
  logic idle;
  assign idle = (state_q == FILL) && (cnt_q != '0) && !pend_q && bus.empty;

  fifo_flush_timer #(.TIMEOUT(TIMEOUT)) u_flush_timer (
    .rd_clk   (rd_clk),
    .reset    (reset),
    .clr_i    (capture || (state_q != FILL) || (cnt_q == '0)),
    .run_i    (idle),
    .expire_o (flush)
  );
`else
  assign flush = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    keep_d  = keep_q;
    uf_d    = uf_q || (pend_q && bus.rd_error);
    case (state_q)
      FILL: begin
        if (capture) begin
          data_d[cnt_q[LW-1:0]] = bus.rdata;
          cnt_d                 = cnt_q + CW'(1);
          if (int'(cnt_q) == BYTES - 1) begin
            state_d = HOLD;
            keep_d  = '1;
          end
        end else if (flush) begin
          state_d = HOLD;
          for (int i = 0; i < BYTES; i++) keep_d[i] = (i < int'(cnt_q));
        end
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = FILL;
          cnt_d   = '0;
          data_d  = '0;
          keep_d  = '0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge rd_clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      data_q  <= '0;
      keep_q  <= '0;
      uf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= rd_en;
      data_q  <= data_d;
      keep_q  <= keep_d;
      uf_q    <= uf_d;
    end
  end

  assign bus.rd_en     = rd_en;
  assign bus.out_data  = data_q;
  assign bus.out_keep  = keep_q;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.underflow = uf_q;
endmodule
